ofmap_writeback: RTL

//  Memory-side sink for the accumulation node: takes finished convolution sums off the NoC router,

---
 rtl/noc_pkg.sv | 47 ++++
 rtl/ofmap_ram.sv | 41 ++++
 rtl/ofmap_writeback.sv | 117 +++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC packet layout, writeback FSM states and the activation conversion.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package noc_pkg;

   localparam int PKT_W   = 20;
   localparam int ID_W    = 5;
   localparam int DATA_W  = 10;
   localparam int OUT_W   = 8;

   // Field offsets inside a packet: {src, dst, sum}
   localparam int SUM_LSB = 0;
   localparam int DST_LSB = DATA_W;
   localparam int SRC_LSB = DATA_W + ID_W;

   localparam int SAT_MAX = (2 ** OUT_W) - 1;

   typedef struct packed {
      logic [ID_W-1:0]   src;
      logic [ID_W-1:0]   dst;
      logic [DATA_W-1:0] sum;
   } noc_pkt_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      REPORT
   } wb_state_t;

   // Two's-complement sum to unsigned activation. With relu_en the negative half
   // collapses to 0; without it the magnitude is kept. -2^(DATA_W-1) negates to
   // itself, which reads as a large unsigned magnitude and therefore saturates.
   function automatic logic [OUT_W-1:0] relu_sat(input logic [DATA_W-1:0] sum,
                                                 input logic              relu_en);
      logic [DATA_W-1:0] mag;
      logic [OUT_W-1:0]  res;
      mag = sum[DATA_W-1] ? ((~sum) + DATA_W'(1)) : sum;
      if (sum[DATA_W-1] && relu_en)
         res = '0;
      else if (mag > DATA_W'(SAT_MAX))
         res = '1;
      else
         res = mag[OUT_W-1:0];
      return res;
   endfunction

endpackage

// File: rtl/ofmap_ram.sv
// Output-feature-map buffer: one write port, one registered read port, no content reset.
// Latency: write visible to a read issued the next cycle; read data 1 cycle after rd_en.
// Backpressure: none; a same-address read and write in one cycle returns the old word.
module ofmap_ram
   import noc_pkg::*;
#(
   parameter int DEPTH = 75,
   parameter int AW    = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [OUT_W-1:0] i_wr_data,
   input  logic             i_rd_en,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [OUT_W-1:0] o_rd_data
);

   localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

   logic [OUT_W-1:0] r_mem [DEPTH];
   logic [OUT_W-1:0] r_rd_data;

   // Storage array; the pointer never exceeds DEPTH-1, the guard keeps it in bounds anyway
   always_ff @(posedge clk) begin
      if (i_wr_en && (i_wr_addr < DEPTH_A))
         r_mem[i_wr_addr] <= i_wr_data;
   end

   // Registered read; nonblocking update of r_mem gives read-old-data on collisions
   always_ff @(posedge clk) begin
      if (rst)
         r_rd_data <= '0;
      else if (i_rd_en)
         r_rd_data <= (i_rd_addr < DEPTH_A) ? r_mem[i_rd_addr] : '0;
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ofmap_writeback.sv
// NoC sink: filters packets by destination, applies ReLU/saturation, stores results in order.
// Latency: accept-to-readable 1 cycle; done_valid rises the cycle after the final accept.
// Backpressure: in_ready high only in RUN (one packet per cycle); done report held until done_ready.
module ofmap_writeback
   import noc_pkg::*;
#(
   parameter int              TOT_NUM = 75,
   parameter logic [ID_W-1:0] MY_ID   = '0,
   parameter bit              RELU_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PKT_W-1:0] in_data,
   input  logic             start,
   output logic             done_valid,
   input  logic             done_ready,
   input  logic             rd_en,
   input  logic [6:0]       rd_addr,
   output logic [OUT_W-1:0] rd_data,
   output logic [6:0]       wr_ptr,
   output logic [7:0]       drop_cnt
);

   localparam logic [6:0] LAST_IDX = 7'(TOT_NUM - 1);

   wb_state_t         r_state;
   logic              r_in_ready;
   logic              r_done_valid;
   logic [6:0]        r_wr_ptr;
   logic [7:0]        r_drop_cnt;

   logic [ID_W-1:0]   w_dst;
   logic [DATA_W-1:0] w_sum;
   logic [ID_W-1:0]   w_unused_src;
   logic              w_accept;
   logic              w_mine;
   logic              w_wr_en;
   logic [OUT_W-1:0]  w_wr_data;

   assign w_dst        = in_data[DST_LSB +: ID_W];
   assign w_sum        = in_data[SUM_LSB +: DATA_W];
   assign w_unused_src = in_data[SRC_LSB +: ID_W];

   assign w_accept  = in_valid && r_in_ready;
   assign w_mine    = (w_dst == MY_ID);
   assign w_wr_en   = w_accept && w_mine;
   assign w_wr_data = relu_sat(w_sum, RELU_EN);

   // Layer control: IDLE -> RUN on start, RUN -> REPORT on the last store, REPORT -> IDLE on ack
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_in_ready   <= 1'b0;
         r_done_valid <= 1'b0;
         r_wr_ptr     <= '0;
         r_drop_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state    <= RUN;
                  r_in_ready <= 1'b1;
                  r_wr_ptr   <= '0;
                  r_drop_cnt <= '0;
               end
            end
            RUN: begin
               if (w_accept) begin
                  if (w_mine) begin
                     r_wr_ptr <= r_wr_ptr + 7'd1;
                     if (r_wr_ptr == LAST_IDX) begin
                        r_state      <= REPORT;
                        r_in_ready   <= 1'b0;
                        r_done_valid <= 1'b1;
                     end
                  end else if (r_drop_cnt != 8'hFF) begin
                     r_drop_cnt <= r_drop_cnt + 8'd1;
                  end
               end
            end
            REPORT: begin
               if (done_ready) begin
                  r_state      <= IDLE;
                  r_done_valid <= 1'b0;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_in_ready   <= 1'b0;
               r_done_valid <= 1'b0;
            end
         endcase
      end
   end

   ofmap_ram #(
      .DEPTH (TOT_NUM),
      .AW    (7)
   ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_wr_data),
      .i_rd_en   (rd_en),
      .i_rd_addr (rd_addr),
      .o_rd_data (rd_data)
   );

   assign in_ready   = r_in_ready;
   assign done_valid = r_done_valid;
   assign wr_ptr     = r_wr_ptr;
   assign drop_cnt   = r_drop_cnt;

endmodule
